// File: rtl/ex_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage_pkg
// Purpose  : Shared ALU op codes, memory opcodes, control bit indices and the
//            EX/MEM pipeline register layout for the execute/memory stage.
// Revision : 1.0  initial release
// ============================================================================
package ex_mem_stage_pkg;

    localparam logic [4:0] ALUOP_ADD  = 5'd0;
    localparam logic [4:0] ALUOP_SUB  = 5'd1;
    localparam logic [4:0] ALUOP_AND  = 5'd2;
    localparam logic [4:0] ALUOP_OR   = 5'd3;
    localparam logic [4:0] ALUOP_XOR  = 5'd4;
    localparam logic [4:0] ALUOP_NOR  = 5'd5;
    localparam logic [4:0] ALUOP_SLT  = 5'd6;
    localparam logic [4:0] ALUOP_SLTU = 5'd7;
    localparam logic [4:0] ALUOP_SLL  = 5'd8;
    localparam logic [4:0] ALUOP_SRL  = 5'd9;
    localparam logic [4:0] ALUOP_SRA  = 5'd10;
    localparam logic [4:0] ALUOP_LUI  = 5'd11;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    localparam int CTRL_MENWR    = 6;
    localparam int CTRL_B        = 5;
    localparam int CTRL_MENTOREG = 4;
    localparam int CTRL_REGWR    = 3;
    localparam int CTRL_JR       = 2;
    localparam int CTRL_JAR      = 1;
    localparam int CTRL_J        = 0;

    typedef enum logic [1:0] {
        ACC_BYTE = 2'd0,
        ACC_HALF = 2'd1,
        ACC_WORD = 2'd2
    } acc_size_e;

    typedef struct packed {
        logic [6:0]  ctrl;
        logic        zero;
        logic [4:0]  rw;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] aluout;
        logic [31:0] busa;
        logic [31:0] busb;
        logic [31:0] jpc;
        logic [31:0] bpc;
        logic [31:0] pcnew;
        logic [31:0] instr;
    } ex_mem_t;

    function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic sign);
        return sign ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_stage_dm_mem.sv
`default_nettype none
// ============================================================================
// Module   : dm_mem
// Purpose  : Little-endian byte-lane data memory with sized stores and
//            sign/zero-extending typed loads; combinational read.
// Revision : 1.0  initial release
// ============================================================================
module dm_mem
    import ex_mem_stage_pkg::*;
#(
    parameter int DM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [5:0]  op,
    output logic [31:0] rdata
);

    localparam int AW = $clog2(DM_WORDS);

    logic [AW-1:0] w_idx;
    logic          w_unused_addr;
    acc_size_e     w_wsize;
    acc_size_e     w_rsize;
    logic          w_rsigned;
    logic [3:0]    w_be;
    logic [31:0]   w_wlanes;
    logic [31:0]   w_rword;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    // Upper address bits fall off so accesses past the end wrap around
    assign w_idx         = addr[AW+1:2];
    assign w_unused_addr = ^addr[31:AW+2];

    always_comb begin
        w_wsize = ACC_WORD;
        case (op)
            OP_SB:   w_wsize = ACC_BYTE;
            OP_SH:   w_wsize = ACC_HALF;
            default: w_wsize = ACC_WORD;
        endcase
    end

    always_comb begin
        w_rsize   = ACC_WORD;
        w_rsigned = 1'b0;
        case (op)
            OP_LB:   begin w_rsize = ACC_BYTE; w_rsigned = 1'b1; end
            OP_LBU:  w_rsize = ACC_BYTE;
            OP_LH:   begin w_rsize = ACC_HALF; w_rsigned = 1'b1; end
            OP_LHU:  w_rsize = ACC_HALF;
            default: w_rsize = ACC_WORD;
        endcase
    end

    always_comb begin
        w_be     = 4'hF;
        w_wlanes = wdata;
        case (w_wsize)
            ACC_BYTE: begin
                w_be     = 4'b0001 << addr[1:0];
                w_wlanes = {4{wdata[7:0]}};
            end
            ACC_HALF: begin
                w_be     = addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{wdata[15:0]}};
            end
            default: begin
                w_be     = 4'hF;
                w_wlanes = wdata;
            end
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DM_WORDS] = '{default: 8'h00};

        always_ff @(posedge clk) begin
            if (we && w_be[gi]) begin
                lane_mem[w_idx] <= w_wlanes[8*gi +: 8];
            end
        end

        assign w_rword[8*gi +: 8] = lane_mem[w_idx];
    end

    always_comb begin
        w_byte = w_rword[7:0];
        case (addr[1:0])
            2'd0:    w_byte = w_rword[7:0];
            2'd1:    w_byte = w_rword[15:8];
            2'd2:    w_byte = w_rword[23:16];
            default: w_byte = w_rword[31:24];
        endcase
        w_half = addr[1] ? w_rword[31:16] : w_rword[15:0];
    end

    always_comb begin
        rdata = w_rword;
        case (w_rsize)
            ACC_BYTE: rdata = {{24{w_rsigned & w_byte[7]}}, w_byte};
            ACC_HALF: rdata = {{16{w_rsigned & w_half[15]}}, w_half};
            default:  rdata = w_rword;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Purpose  : MIPS execute stage with operand forwarding, load-use detection,
//            EX/MEM pipeline register and the data memory.
// Revision : 1.0  initial release
// ============================================================================
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_extop,
    input  logic        ex_alusrc,
    input  logic        ex_shfsrc,
    input  logic [4:0]  ex_shamt,
    input  logic [4:0]  ex_aluop,
    input  logic [15:0] ex_imm,
    input  logic [31:0] ex_pcnew,
    input  logic [31:0] ex_busa,
    input  logic [31:0] ex_busb,
    input  logic [25:0] ex_target,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  ex_rw,
    input  logic [6:0]  ex_ctrl,
    input  logic [31:0] ex_instr,
    input  logic        wb_regwr,
    input  logic [4:0]  wb_rw,
    input  logic [31:0] wb_busw,
    input  logic        flush,
    output logic        load_ok,
    output logic [6:0]  me_ctrl,
    output logic        me_zero,
    output logic [4:0]  me_rw,
    output logic [4:0]  me_rs,
    output logic [4:0]  me_rt,
    output logic [31:0] me_aluout,
    output logic [31:0] me_busa,
    output logic [31:0] me_busb,
    output logic [31:0] me_jpc,
    output logic [31:0] me_bpc,
    output logic [31:0] me_pcnew,
    output logic [31:0] me_instr,
    output logic [31:0] me_rdata
);

    ex_mem_t     em_q;
    ex_mem_t     em_d;

    logic        w_mem_fwd_ok;
    logic [31:0] w_fwd_a;
    logic [31:0] w_fwd_b;
    logic [31:0] w_imm_ext;
    logic [31:0] w_alu_b;
    logic [4:0]  w_sa;
    logic [31:0] w_alu_res;
    logic [31:0] w_bpc;
    logic [31:0] w_jpc;
    logic [31:0] w_st_data;
    logic        w_dm_we;

    // A load in MEM has no data yet, so it is never a forwarding source
    assign w_mem_fwd_ok = em_q.ctrl[CTRL_REGWR] && !em_q.ctrl[CTRL_MENTOREG];

    always_comb begin
        if (ex_rs != 5'd0 && w_mem_fwd_ok && em_q.rw == ex_rs) begin
            w_fwd_a = em_q.aluout;
        end else if (ex_rs != 5'd0 && wb_regwr && wb_rw == ex_rs) begin
            w_fwd_a = wb_busw;
        end else begin
            w_fwd_a = ex_busa;
        end

        if (ex_rt != 5'd0 && w_mem_fwd_ok && em_q.rw == ex_rt) begin
            w_fwd_b = em_q.aluout;
        end else if (ex_rt != 5'd0 && wb_regwr && wb_rw == ex_rt) begin
            w_fwd_b = wb_busw;
        end else begin
            w_fwd_b = ex_busb;
        end
    end

    assign load_ok = !(em_q.ctrl[CTRL_REGWR] && em_q.ctrl[CTRL_MENTOREG] && em_q.rw != 5'd0 &&
                       (em_q.rw == ex_rs || em_q.rw == ex_rt));

    assign w_imm_ext = ext_imm(ex_imm, ex_extop);
    assign w_alu_b   = ex_alusrc ? w_imm_ext : w_fwd_b;
    assign w_sa      = ex_shfsrc ? w_fwd_a[4:0] : ex_shamt;

    always_comb begin
        w_alu_res = 32'd0;
        case (ex_aluop)
            ALUOP_ADD:  w_alu_res = w_fwd_a + w_alu_b;
            ALUOP_SUB:  w_alu_res = w_fwd_a - w_alu_b;
            ALUOP_AND:  w_alu_res = w_fwd_a & w_alu_b;
            ALUOP_OR:   w_alu_res = w_fwd_a | w_alu_b;
            ALUOP_XOR:  w_alu_res = w_fwd_a ^ w_alu_b;
            ALUOP_NOR:  w_alu_res = ~(w_fwd_a | w_alu_b);
            ALUOP_SLT:  w_alu_res = {31'd0, $signed(w_fwd_a) < $signed(w_alu_b)};
            ALUOP_SLTU: w_alu_res = {31'd0, w_fwd_a < w_alu_b};
            ALUOP_SLL:  w_alu_res = w_alu_b << w_sa;
            ALUOP_SRL:  w_alu_res = w_alu_b >> w_sa;
            ALUOP_SRA:  w_alu_res = $unsigned($signed(w_alu_b) >>> w_sa);
            ALUOP_LUI:  w_alu_res = {ex_imm, 16'h0000};
            default:    w_alu_res = 32'd0;
        endcase
    end

    assign w_bpc = ex_pcnew + {{14{ex_imm[15]}}, ex_imm, 2'b00};
    assign w_jpc = {ex_pcnew[31:28], ex_target, 2'b00};

    always_comb begin
        em_d.ctrl   = ex_ctrl;
        em_d.zero   = (w_alu_res == 32'd0);
        em_d.rw     = ex_rw;
        em_d.rs     = ex_rs;
        em_d.rt     = ex_rt;
        em_d.aluout = w_alu_res;
        em_d.busa   = w_fwd_a;
        em_d.busb   = w_fwd_b;
        em_d.jpc    = w_jpc;
        em_d.bpc    = w_bpc;
        em_d.pcnew  = ex_pcnew;
        em_d.instr  = ex_instr;
        // Squashed or stalled instructions enter MEM as a bubble
        if (flush || !load_ok) begin
            em_d.ctrl  = 7'd0;
            em_d.instr = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            em_q <= '0;
        end else begin
            em_q <= em_d;
        end
    end

    assign me_ctrl   = em_q.ctrl;
    assign me_zero   = em_q.zero;
    assign me_rw     = em_q.rw;
    assign me_rs     = em_q.rs;
    assign me_rt     = em_q.rt;
    assign me_aluout = em_q.aluout;
    assign me_busa   = em_q.busa;
    assign me_busb   = em_q.busb;
    assign me_jpc    = em_q.jpc;
    assign me_bpc    = em_q.bpc;
    assign me_pcnew  = em_q.pcnew;
    assign me_instr  = em_q.instr;

    // Store data may still be in flight from the instruction now in WB
    assign w_st_data = (wb_regwr && wb_rw == em_q.rt && wb_rw != 5'd0) ? wb_busw : em_q.busb;
    assign w_dm_we   = em_q.ctrl[CTRL_MENWR] & reset;

    dm_mem #(
        .DM_WORDS (DM_WORDS)
    ) u_dm_mem (
        .clk   (clk),
        .we    (w_dm_we),
        .addr  (em_q.aluout),
        .wdata (w_st_data),
        .op    (em_q.instr[31:26]),
        .rdata (me_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Purpose  : Self-checking bench for ex_mem_stage against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_mem_stage;

    localparam int DMW = 1024;
    localparam int NBYTES = DMW * 4;

    localparam logic [5:0] T_LW = 6'b100011, T_LB = 6'b100000, T_LBU = 6'b100100;
    localparam logic [5:0] T_LH = 6'b100001, T_LHU = 6'b100101;
    localparam logic [5:0] T_SW = 6'b101011, T_SB = 6'b101000, T_SH = 6'b101001;
    localparam logic [6:0] C_MENWR = 7'b1000000, C_MENTOREG = 7'b0010000, C_REGWR = 7'b0001000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_extop, ex_alusrc, ex_shfsrc;
    logic [4:0]  ex_shamt, ex_aluop;
    logic [15:0] ex_imm;
    logic [31:0] ex_pcnew, ex_busa, ex_busb, ex_instr;
    logic [25:0] ex_target;
    logic [4:0]  ex_rs, ex_rt, ex_rw;
    logic [6:0]  ex_ctrl;
    logic        wb_regwr;
    logic [4:0]  wb_rw;
    logic [31:0] wb_busw;
    logic        flush;
    logic        load_ok;
    logic [6:0]  me_ctrl;
    logic        me_zero;
    logic [4:0]  me_rw, me_rs, me_rt;
    logic [31:0] me_aluout, me_busa, me_busb, me_jpc, me_bpc, me_pcnew, me_instr, me_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] ref_mem [NBYTES];

    ex_mem_stage #(.DM_WORDS(DMW)) dut (
        .clk(clk), .reset(reset), .ex_extop(ex_extop), .ex_alusrc(ex_alusrc),
        .ex_shfsrc(ex_shfsrc), .ex_shamt(ex_shamt), .ex_aluop(ex_aluop), .ex_imm(ex_imm),
        .ex_pcnew(ex_pcnew), .ex_busa(ex_busa), .ex_busb(ex_busb), .ex_target(ex_target),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rw(ex_rw), .ex_ctrl(ex_ctrl), .ex_instr(ex_instr),
        .wb_regwr(wb_regwr), .wb_rw(wb_rw), .wb_busw(wb_busw), .flush(flush),
        .load_ok(load_ok), .me_ctrl(me_ctrl), .me_zero(me_zero), .me_rw(me_rw),
        .me_rs(me_rs), .me_rt(me_rt), .me_aluout(me_aluout), .me_busa(me_busa),
        .me_busb(me_busb), .me_jpc(me_jpc), .me_bpc(me_bpc), .me_pcnew(me_pcnew),
        .me_instr(me_instr), .me_rdata(me_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_extop = 1'b0; ex_alusrc = 1'b0; ex_shfsrc = 1'b0; ex_shamt = 5'd0;
        ex_aluop = 5'd0; ex_imm = 16'd0; ex_pcnew = 32'd0; ex_busa = 32'd0;
        ex_busb = 32'd0; ex_target = 26'd0; ex_rs = 5'd0; ex_rt = 5'd0; ex_rw = 5'd0;
        ex_ctrl = 7'd0; ex_instr = 32'd0; wb_regwr = 1'b0; wb_rw = 5'd0;
        wb_busw = 32'd0; flush = 1'b0;
    endtask

    // Reference ALU straight from the operation table
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sa,
                                            input logic [15:0] imm);
        int sb;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return ~(a | b);
            5'd6:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            5'd7:  return (a < b) ? 32'd1 : 32'd0;
            5'd8:  return b << sa;
            5'd9:  return b >> sa;
            5'd10: begin sb = int'(b); return 32'(sb >>> sa); end
            5'd11: return {imm, 16'h0000};
            default: return 32'd0;
        endcase
    endfunction

    function automatic void ref_store(input logic [5:0] op, input logic [31:0] addr,
                                      input logic [31:0] data);
        int a;
        a = int'(addr % NBYTES);
        if (op == T_SB) begin
            ref_mem[a] = data[7:0];
        end else if (op == T_SH) begin
            a = a - (a % 2);
            ref_mem[a] = data[7:0]; ref_mem[a+1] = data[15:8];
        end else begin
            a = a - (a % 4);
            for (int k = 0; k < 4; k++) ref_mem[a+k] = data[8*k +: 8];
        end
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr);
        int a;
        logic [15:0] h;
        a = int'(addr % NBYTES);
        if (op == T_LB)  return {{24{ref_mem[a][7]}}, ref_mem[a]};
        if (op == T_LBU) return {24'd0, ref_mem[a]};
        a = a - (a % 2);
        h = {ref_mem[a+1], ref_mem[a]};
        if (op == T_LH)  return {{16{h[15]}}, h};
        if (op == T_LHU) return {16'd0, h};
        a = a - (a % 4);
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    task automatic issue_store(input logic [5:0] op, input logic [15:0] addr, input logic [31:0] data);
        clear_ex();
        ex_ctrl = C_MENWR; ex_instr = {op, 26'd0}; ex_alusrc = 1'b1; ex_imm = addr; ex_busb = data;
        step();
        ref_store(op, {16'd0, addr}, data);
    endtask

    task automatic issue_load(input logic [5:0] op, input logic [15:0] addr);
        clear_ex();
        ex_ctrl = C_REGWR | C_MENTOREG; ex_rw = 5'd3; ex_instr = {op, 26'd0};
        ex_alusrc = 1'b1; ex_imm = addr;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_ex();
        ex_ctrl = 7'h7F; ex_instr = 32'hFFFF_FFFF; ex_busa = 32'h1234_5678; ex_pcnew = 32'h400;
        step(); step();
        n_tests++; if (me_ctrl !== 7'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", me_ctrl); end
        n_tests++; if (me_instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", me_instr); end
        n_tests++; if ({me_aluout, me_busa, me_busb, me_pcnew} !== 128'd0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h want 0", me_aluout, me_busa, me_busb, me_pcnew); end
        n_tests++; if ({me_jpc, me_bpc, me_zero, me_rw, me_rs, me_rt} !== 80'd0) begin
            n_fail++; $display("FAIL reset_misc: got %h %h %b %h want 0", me_jpc, me_bpc, me_zero, me_rw); end
        reset = 1'b1;
        clear_ex();
        step();
    endtask

    task automatic test_forward();
        clear_ex();
        ex_ctrl = C_REGWR; ex_rw = 5'd5; ex_alusrc = 1'b1; ex_imm = 16'd7;
        step();
        clear_ex();
        ex_rs = 5'd5; ex_busa = 32'd1;
        step();
        n_tests++; if (me_aluout !== 32'd7) begin n_fail++; $display("FAIL fwd_mem_alu: got %h want 7", me_aluout); end
        n_tests++; if (me_busa !== 32'd7) begin n_fail++; $display("FAIL fwd_mem_busa: got %h want 7", me_busa); end
        clear_ex();
        ex_rt = 5'd5; ex_busb = 32'd2; wb_regwr = 1'b1; wb_rw = 5'd5; wb_busw = 32'd9;
        step();
        n_tests++; if (me_busb !== 32'd9) begin n_fail++; $display("FAIL fwd_wb_busb: got %h want 9", me_busb); end
        n_tests++; if (me_aluout !== 32'd9) begin n_fail++; $display("FAIL fwd_wb_alu: got %h want 9", me_aluout); end
    endtask

    task automatic test_priority();
        clear_ex();
        ex_ctrl = C_REGWR; ex_rw = 5'd5; ex_alusrc = 1'b1; ex_imm = 16'd3;
        step();
        clear_ex();
        wb_regwr = 1'b1; wb_rw = 5'd5; wb_busw = 32'd9; ex_rs = 5'd5; ex_busa = 32'd1;
        step();
        n_tests++; if (me_aluout !== 32'd3) begin n_fail++; $display("FAIL fwd_priority: got %h want 3", me_aluout); end
        clear_ex();
        ex_ctrl = C_REGWR; ex_rw = 5'd0; ex_alusrc = 1'b1; ex_imm = 16'd3;
        step();
        clear_ex();
        wb_regwr = 1'b1; wb_rw = 5'd0; wb_busw = 32'd9; ex_rs = 5'd0; ex_busa = 32'd1;
        step();
        n_tests++; if (me_aluout !== 32'd1) begin n_fail++; $display("FAIL fwd_r0: got %h want 1", me_aluout); end
    endtask

    task automatic test_load_use();
        clear_ex();
        ex_ctrl = C_REGWR | C_MENTOREG; ex_rw = 5'd8; ex_instr = {T_LW, 26'd0};
        ex_alusrc = 1'b1; ex_imm = 16'h40;
        step();
        clear_ex();
        ex_ctrl = C_REGWR; ex_rs = 5'd8; ex_instr = 32'h0123_4567;
        #1;
        n_tests++; if (load_ok !== 1'b0) begin n_fail++; $display("FAIL load_use_rs: load_ok=%b want 0", load_ok); end
        step();
        n_tests++; if (me_ctrl !== 7'd0) begin n_fail++; $display("FAIL load_use_bubble_ctrl: got %h want 0", me_ctrl); end
        n_tests++; if (me_instr !== 32'd0) begin n_fail++; $display("FAIL load_use_bubble_instr: got %h want 0", me_instr); end
        n_tests++; if (load_ok !== 1'b1) begin n_fail++; $display("FAIL load_use_release: load_ok=%b want 1", load_ok); end
        clear_ex();
        ex_ctrl = C_REGWR | C_MENTOREG; ex_rw = 5'd8; ex_instr = {T_LW, 26'd0};
        step();
        clear_ex();
        ex_rt = 5'd8;
        #1;
        n_tests++; if (load_ok !== 1'b0) begin n_fail++; $display("FAIL load_use_rt: load_ok=%b want 0", load_ok); end
        ex_rt = 5'd9;
        #1;
        n_tests++; if (load_ok !== 1'b1) begin n_fail++; $display("FAIL load_use_nohit: load_ok=%b want 1", load_ok); end
        step();
    endtask

    task automatic test_branch();
        logic [31:0] exp_b, exp_j;
        int off;
        clear_ex();
        ex_pcnew = 32'h100; ex_imm = 16'hFFFF; ex_extop = 1'b1; ex_target = 26'h3;
        step();
        n_tests++; if (me_bpc !== 32'h0000_00FC) begin n_fail++; $display("FAIL bpc_fixed: got %h want 000000fc", me_bpc); end
        n_tests++; if (me_jpc !== 32'h0000_000C) begin n_fail++; $display("FAIL jpc_fixed: got %h want 0000000c", me_jpc); end
        for (int i = 0; i < 8; i++) begin
            clear_ex();
            ex_pcnew = $urandom; ex_imm = 16'($urandom); ex_target = 26'($urandom);
            off = int'($signed(ex_imm));
            exp_b = ex_pcnew + 32'(off * 4);
            exp_j = (ex_pcnew & 32'hF000_0000) + (32'(ex_target) * 4);
            step();
            n_tests++; if (me_bpc !== exp_b) begin n_fail++; $display("FAIL bpc_rand: got %h want %h", me_bpc, exp_b); end
            n_tests++; if (me_jpc !== exp_j) begin n_fail++; $display("FAIL jpc_rand: got %h want %h", me_jpc, exp_j); end
        end
    endtask

    task automatic test_memory();
        logic [5:0] lops [5];
        logic [5:0] sops [3];
        logic [5:0] op;
        logic [15:0] a;
        logic [31:0] exp;
        lops = '{T_LW, T_LB, T_LBU, T_LH, T_LHU};
        sops = '{T_SW, T_SB, T_SH};
        issue_store(T_SW, 16'h10, 32'h80FF_7F01);
        issue_load(T_LB, 16'h11);
        n_tests++; if (me_rdata !== 32'h0000_007F) begin n_fail++; $display("FAIL lb_11: got %h want 0000007f", me_rdata); end
        issue_load(T_LB, 16'h12);
        n_tests++; if (me_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL lb_12: got %h want ffffffff", me_rdata); end
        issue_load(T_LHU, 16'h12);
        n_tests++; if (me_rdata !== 32'h0000_80FF) begin n_fail++; $display("FAIL lhu_12: got %h want 000080ff", me_rdata); end
        issue_load(T_LH, 16'h13);
        n_tests++; if (me_rdata !== 32'hFFFF_80FF) begin n_fail++; $display("FAIL lh_13: got %h want ffff80ff", me_rdata); end
        issue_load(T_LW, 16'h1013);
        n_tests++; if (me_rdata !== 32'h80FF_7F01) begin n_fail++; $display("FAIL lw_wrap: got %h want 80ff7f01", me_rdata); end
        // Store data supplied late from WB, and not when WB targets r0
        clear_ex();
        ex_ctrl = C_MENWR; ex_instr = {T_SW, 26'd0}; ex_alusrc = 1'b1; ex_imm = 16'h24;
        ex_rt = 5'd7; ex_busb = 32'h1111_1111;
        step();
        clear_ex();
        wb_regwr = 1'b1; wb_rw = 5'd7; wb_busw = 32'hCAFE_F00D;
        step();
        issue_load(T_LW, 16'h24);
        n_tests++; if (me_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL store_fwd: got %h want cafef00d", me_rdata); end
        clear_ex();
        ex_ctrl = C_MENWR; ex_instr = {T_SW, 26'd0}; ex_alusrc = 1'b1; ex_imm = 16'h28;
        ex_busb = 32'h5555_5555;
        step();
        clear_ex();
        wb_regwr = 1'b1; wb_rw = 5'd0; wb_busw = 32'h0BAD_0BAD;
        step();
        issue_load(T_LW, 16'h28);
        n_tests++; if (me_rdata !== 32'h5555_5555) begin n_fail++; $display("FAIL store_fwd_r0: got %h want 55555555", me_rdata); end
        ref_mem[16'h24] = 8'h0D; ref_mem[16'h25] = 8'hF0; ref_mem[16'h26] = 8'hFE; ref_mem[16'h27] = 8'hCA;
        for (int k = 0; k < 4; k++) ref_mem[16'h28 + k] = 8'h55;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                op = sops[$urandom_range(0, 2)];
                issue_store(op, a, $urandom);
            end else begin
                op = lops[$urandom_range(0, 4)];
                issue_load(op, a);
                exp = ref_load(op, {16'd0, a});
                n_tests++; if (me_rdata !== exp) begin
                    n_fail++; $display("FAIL mem_rand op=%b addr=%h: got %h want %h", op, a, me_rdata, exp); end
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] exp;
        clear_ex();
        ex_ctrl = C_MENWR; ex_instr = {T_SW, 26'd0}; ex_alusrc = 1'b1; ex_imm = 16'h200;
        ex_busb = 32'hDEAD_BEEF; flush = 1'b1;
        step();
        n_tests++; if (me_ctrl !== 7'd0) begin n_fail++; $display("FAIL flush_ctrl: got %h want 0", me_ctrl); end
        n_tests++; if (me_instr !== 32'd0) begin n_fail++; $display("FAIL flush_instr: got %h want 0", me_instr); end
        clear_ex();
        step();
        issue_load(T_LW, 16'h200);
        exp = ref_load(T_LW, 32'h200);
        n_tests++; if (me_rdata !== exp) begin n_fail++; $display("FAIL flush_nostore: got %h want %h", me_rdata, exp); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        clear_ex();
        ex_ctrl = C_MENWR; ex_instr = {T_SW, 26'd0}; ex_alusrc = 1'b1; ex_imm = 16'h300;
        ex_busb = 32'h1234_5678; ex_pcnew = 32'h8000_0040; ex_target = 26'h155;
        step();
        clear_ex();
        reset = 1'b0;
        ex_ctrl = C_REGWR; ex_busa = 32'h77; ex_instr = 32'hFFFF_0000; ex_pcnew = 32'h44;
        step();
        n_tests++; if (me_ctrl !== 7'd0) begin n_fail++; $display("FAIL rstmid_ctrl: got %h want 0", me_ctrl); end
        n_tests++; if ({me_aluout, me_busa, me_busb, me_instr} !== 128'd0) begin
            n_fail++; $display("FAIL rstmid_data: got %h %h %h %h want 0", me_aluout, me_busa, me_busb, me_instr); end
        n_tests++; if ({me_jpc, me_bpc, me_pcnew, me_zero} !== 97'd0) begin
            n_fail++; $display("FAIL rstmid_pc: got %h %h %h %b want 0", me_jpc, me_bpc, me_pcnew, me_zero); end
        reset = 1'b1;
        issue_load(T_LW, 16'h300);
        exp = ref_load(T_LW, 32'h300);
        n_tests++; if (me_rdata !== exp) begin n_fail++; $display("FAIL rstmid_nostore: got %h want %h", me_rdata, exp); end
    endtask

    // Model: each register read sees the newest in-flight value (MEM, then WB, then regfile)
    task automatic test_random_alu();
        logic        mem_v;
        logic [4:0]  mem_rw;
        logic [31:0] mem_val;
        logic [31:0] a, b, bsel, res;
        logic [4:0]  sa;
        logic [6:0]  ctl;
        logic [4:0]  rw;
        clear_ex();
        step();
        mem_v = 1'b0; mem_rw = 5'd0; mem_val = 32'd0;
        for (int i = 0; i < 60; i++) begin
            clear_ex();
            ex_aluop = 5'($urandom_range(0, 15));
            ex_busa = $urandom; ex_busb = (i % 7 == 0) ? ex_busa : $urandom;
            ex_imm = 16'($urandom); ex_extop = 1'($urandom); ex_alusrc = 1'($urandom);
            ex_shfsrc = 1'($urandom); ex_shamt = 5'($urandom);
            ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
            ex_rw = 5'($urandom_range(0, 3));
            ex_ctrl = ($urandom_range(0, 1) == 1) ? C_REGWR : 7'd0;
            wb_regwr = 1'($urandom); wb_rw = 5'($urandom_range(0, 3)); wb_busw = $urandom;
            ex_pcnew = $urandom;
            if (ex_rs != 0 && mem_v && mem_rw == ex_rs) a = mem_val;
            else if (ex_rs != 0 && wb_regwr && wb_rw == ex_rs) a = wb_busw;
            else a = ex_busa;
            if (ex_rt != 0 && mem_v && mem_rw == ex_rt) b = mem_val;
            else if (ex_rt != 0 && wb_regwr && wb_rw == ex_rt) b = wb_busw;
            else b = ex_busb;
            bsel = ex_alusrc ? {{16{ex_extop & ex_imm[15]}}, ex_imm} : b;
            sa = ex_shfsrc ? a[4:0] : ex_shamt;
            res = ref_alu(ex_aluop, a, bsel, sa, ex_imm);
            ctl = ex_ctrl; rw = ex_rw;
            #1;
            n_tests++; if (load_ok !== 1'b1) begin n_fail++; $display("FAIL alu_load_ok[%0d]: got %b want 1", i, load_ok); end
            step();
            n_tests++; if (me_aluout !== res) begin
                n_fail++; $display("FAIL alu_res[%0d] op=%0d: got %h want %h", i, ctl, me_aluout, res); end
            n_tests++; if (me_zero !== (res == 32'd0)) begin n_fail++; $display("FAIL alu_zero[%0d]: got %b want %b", i, me_zero, res == 32'd0); end
            n_tests++; if (me_busa !== a || me_busb !== b) begin
                n_fail++; $display("FAIL alu_fwd[%0d]: got %h %h want %h %h", i, me_busa, me_busb, a, b); end
            n_tests++; if (me_ctrl !== ctl || me_rw !== rw) begin
                n_fail++; $display("FAIL alu_ctrl[%0d]: got %h %h want %h %h", i, me_ctrl, me_rw, ctl, rw); end
            mem_v = ctl[3]; mem_rw = rw; mem_val = res;
        end
    endtask

    initial begin
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
        clear_ex();
        reset = 1'b0;
        test_reset();
        test_forward();
        test_priority();
        test_load_use();
        test_branch();
        test_memory();
        test_flush();
        test_reset_mid();
        test_random_alu();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
